uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (8N1, fixed baud) among NREQ byte-stream requesters.
//  Round-robin grant per packet; the grant is held until the requester's Last byte is sent.
//  Drives the transmitter's data/start inputs and consumes its TxDone pulse.
//  A watchdog recovers from a missing TxDone or a stalled requester.
// PARAMETERS
//  NREQ      4     number of requesters (2..8)
//  DW        8     data width per byte
//  TIMEOUT   4096  cycles allowed for TxDone (WAIT) or for the next Req (HOLD)
// PORTS
//  Clk       in   1         system clock
//  Rst       in   1         synchronous reset, active-high
//  Req       in   NREQ      per-requester byte valid (level)
//  ReqData   in   NREQ*DW   requester i byte at [i*DW +: DW]
//  ReqLast   in   NREQ      byte is the last of its packet
//  Ack       out  NREQ      1-cycle pulse: requester i byte accepted
//  Gnt       out  NREQ      one-hot owner of the transmitter (held for the packet)
//  TxData    out  DW        byte to the transmitter, stable from TxStart until TxDone
//  TxStart   out  1         1-cycle pulse: start transmission of TxData
//  TxDone    in   1         1-cycle pulse from the transmitter: byte sent
//  Busy      out  1         high in any state other than IDLE
//  Err       out  1         1-cycle pulse: TxDone timeout
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, Ack=0, Gnt=0, TxData=0, TxStart=0, Busy=0, Err=0, cnt=0.
//  FSM states: IDLE, LOAD, WAIT, HOLD.
//  - IDLE: if |Req, select the first set Req at or after the pointer (wrapping).
//    Gnt=onehot(sel) is registered, then go to LOAD.
//  - LOAD (1 cycle): TxData<=ReqData[sel], last_q<=ReqLast[sel], Ack[sel]=1, TxStart=1.
//    Go to WAIT and clear cnt.
//  - WAIT: hold TxData and Gnt. cnt increments each cycle.
//    On TxDone: if last_q, release Gnt, set pointer=sel+1 (mod NREQ), go to IDLE.
//    Otherwise go to HOLD and clear cnt.
//    If cnt==TIMEOUT-1 without TxDone: Err=1, release, pointer=sel+1, go to IDLE.
//  - HOLD: Gnt held. If Req[sel], go to LOAD. Other requesters are ignored.
//    If cnt==TIMEOUT-1 without Req[sel]: release silently (no Err), pointer=sel+1, go to IDLE.
//  Latency: Req sampled in IDLE at cycle t -> Gnt at t+1 -> Ack/TxStart at t+2.
//  HOLD->LOAD adds 1 cycle.
//  Req, ReqData and ReqLast are sampled only in IDLE (arbitration) and HOLD/LOAD (owner only).
//  A requester drops Req the cycle after Ack if it has no further byte.
//  TxDone is ignored outside WAIT, including in the LOAD cycle.
//  TxDone in the same cycle as the timeout: TxDone wins, no Err.
//  Single requester: re-granted immediately after its packet if Req is still high (no idle gap beyond IDLE).
//  Pointer wraps NREQ-1 -> 0. Gnt and Ack are always one-hot or zero.
//  cnt width is $clog2(TIMEOUT). cnt saturates and never wraps.
//  Reset mid-packet: immediate return to reset values. The transmitter is reset by the same domain.
// STRUCTURE
//  Package uart_arb_pkg: state encoding (IDLE/LOAD/WAIT/HOLD), default NREQ/DW/TIMEOUT,
//  and the 8N1 baud divisor constants shared with the transmitter/receiver top.
//  Sub-module rr_arbiter: combinational round-robin priority select (Req, pointer -> onehot, index).
//  The FSM, watchdog counter and data mux stay in uart_tx_arbiter.
// TESTING
//  1 Reset: Rst=1 for 3 cycles with Req=4'b1111 -> all outputs 0, Busy=0, no TxStart.
//  2 Single byte: Req[2]=1, ReqData[2]=8'hA5, ReqLast[2]=1 -> Gnt=4'b0100 at t+1.
//    Ack[2] and TxStart at t+2 with TxData=A5. TxDone at t+10 -> Gnt=0 at t+11, pointer=3.
//  3 Packet lock: req0 sends 3 bytes 11,22,33 (Last on 33) while Req[1] is high.
//    TxData sequence 11,22,33 all under Gnt=0001. Then Gnt=0010.
//  4 Fairness: Req=4'b1111, all single-byte packets ->
//    grant order 0,1,2,3,0 and TxData matches each requester's byte.
//  5 Watchdog: TIMEOUT=16, TxDone never pulses -> Err exactly one pulse 16 cycles after TxStart.
//    Then IDLE and the next requester is granted.
//  6 Corner cases: TxDone during LOAD is ignored. TxDone on the timeout cycle gives no Err.
//    HOLD with Req[sel] low for 16 cycles -> silent release. Rst asserted in WAIT -> reset values.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// State encoding, default sizing and 8N1 baud constants.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } arb_state_t;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 4096;

  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD        = 115_200;
  localparam int BAUD_DIV    = CLK_HZ / BAUD;
  localparam int FRAME_BITS  = 10;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select.
// Picks the first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int i = 0; i < N; i++) begin
      w_j = IW'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of one 8N1 UART transmitter.
// Holds the grant for a whole packet, with a TxDone/stall watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NREQ-1:0]  Req,
  input  logic [NREQ*DW-1:0] ReqData,
  input  logic [NREQ-1:0]  ReqLast,
  output logic [NREQ-1:0]  Ack,
  output logic [NREQ-1:0]  Gnt,
  output logic [DW-1:0]    TxData,
  output logic             TxStart,
  input  logic             TxDone,
  output logic             Busy,
  output logic             Err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_t      r_state;
  arb_state_t      w_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_sel;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_data;
  logic            r_last;
  logic            r_start;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_idx;
  logic            w_tmo;
  logic            w_rel;
  logic            w_err;
  logic            w_clr;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .i_req (Req),
    .i_ptr (r_ptr),
    .o_gnt (w_onehot),
    .o_idx (w_idx)
  );

  assign w_tmo = (r_cnt == CNT_MAX);

  always_comb begin
    w_nxt = r_state;
    w_rel = 1'b0;
    w_err = 1'b0;
    w_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|Req) w_nxt = LOAD;
      end
      LOAD: begin
        w_nxt = WAIT;
        w_clr = 1'b1;
      end
      WAIT: begin
        // TxDone beats a same-cycle timeout
        if (TxDone) begin
          if (r_last) begin
            w_nxt = IDLE;
            w_rel = 1'b1;
          end else begin
            w_nxt = HOLD;
            w_clr = 1'b1;
          end
        end else if (w_tmo) begin
          w_nxt = IDLE;
          w_rel = 1'b1;
          w_err = 1'b1;
        end
      end
      HOLD: begin
        if (Req[r_sel]) begin
          w_nxt = LOAD;
        end else if (w_tmo) begin
          w_nxt = IDLE;
          w_rel = 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_err   <= w_err;
      if (r_state == IDLE && |Req) begin
        r_gnt <= w_onehot;
        r_sel <= w_idx;
      end
      if (r_state == LOAD) begin
        r_data  <= ReqData[int'(r_sel)*DW +: DW];
        r_last  <= ReqLast[r_sel];
        r_ack   <= r_gnt;
        r_start <= 1'b1;
      end
      // Watchdog saturates rather than wrapping
      if (w_clr) begin
        r_cnt <= '0;
      end else if ((r_state == WAIT || r_state == HOLD)
                   && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rel) begin
        r_gnt <= '0;
        r_ptr <= IW'(wrap_inc(int'(r_sel), NREQ));
      end
    end
  end

  assign Ack     = r_ack;
  assign Gnt     = r_gnt;
  assign TxData  = r_data;
  assign TxStart = r_start;
  assign Err     = r_err;
  assign Busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing checks, then a
// randomized packet phase checked by a scoreboard and RR model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct {
    logic [7:0] d;
    bit         last;
  } byte_t;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [N-1:0]  Req;
  logic [N*DW-1:0] ReqData;
  logic [N-1:0]  ReqLast;
  logic [N-1:0]  Ack;
  logic [N-1:0]  Gnt;
  logic [DW-1:0] TxData;
  logic          TxStart;
  logic          TxDone;
  logic          Busy;
  logic          Err;

  logic [N-1:0]    man_req  = '0;
  logic [N*DW-1:0] man_data = '0;
  logic [N-1:0]    man_last = '0;
  logic            man_done = 1'b0;
  logic [N-1:0]    drv_req  = '0;
  logic [N*DW-1:0] drv_data = '0;
  logic [N-1:0]    drv_last = '0;
  logic            auto_done = 1'b0;

  bit drv_auto = 0;
  bit tx_auto  = 0;
  bit mon_en   = 0;

  int total = 0;
  int bad   = 0;
  int rand_errs = 0;

  byte_t rq[N][$];
  byte_t mdl[N][$];
  exp_t  exp_q[$];

  assign Req     = drv_auto ? drv_req  : man_req;
  assign ReqData = drv_auto ? drv_data : man_data;
  assign ReqLast = drv_auto ? drv_last : man_last;
  assign TxDone  = man_done | auto_done;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(
    .NREQ    (N),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Req     (Req),
    .ReqData (ReqData),
    .ReqLast (ReqLast),
    .Ack     (Ack),
    .Gnt     (Gnt),
    .TxData  (TxData),
    .TxStart (TxStart),
    .TxDone  (TxDone),
    .Busy    (Busy),
    .Err     (Err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, want, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_done;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  function automatic void setb(input int i,
                               input logic [7:0] d,
                               input bit l);
    man_data[i*DW +: DW] = d;
    man_last[i] = l;
  endfunction

  // Requester model: one byte per Ack, Req level while bytes remain
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (drv_auto && Ack[i] && rq[i].size() > 0)
          void'(rq[i].pop_front());
        drv_req[i] = rq[i].size() > 0;
        if (rq[i].size() > 0) begin
          drv_data[i*DW +: DW] = rq[i][0].d;
          drv_last[i] = rq[i][0].last;
        end
      end
    end
  end

  // Transmitter model: TxDone a random 1..7 cycles after TxStart
  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge Clk);
      #1;
      auto_done = 1'b0;
      if (tx_auto) begin
        if (Err) rand_errs++;
        if (TxStart) begin
          w = $urandom_range(1, 7);
        end else if (w > 0) begin
          w--;
          if (w == 0) auto_done = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (mon_en && TxStart) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", TxData, e.d);
          chk("sb_ack", Ack, 32'(1 << e.id));
          chk("sb_gnt", Gnt, 32'(1 << e.id));
        end
      end
    end
  end

  initial begin
    int n;
    int e;
    int mp;
    int sel;
    int len;
    bit any;
    byte_t b;
    exp_t x;

    // Reset with all requests high
    Rst = 1'b1;
    man_req = 4'b1111;
    repeat (3) begin
      tick();
      chk("rst_gnt", Gnt, 0);
      chk("rst_outs", {Ack, TxStart, Busy, Err, TxData}, 0);
    end
    man_req = '0;
    Rst = 1'b0;
    tick();

    // Single byte from requester 2
    setb(2, 8'hA5, 1'b1);
    man_req = 4'b0100;
    tick();
    chk("single_gnt", Gnt, 4'b0100);
    chk("single_nostart", TxStart, 0);
    tick();
    chk("single_ack", Ack, 4'b0100);
    chk("single_start", TxStart, 1);
    chk("single_data", TxData, 8'hA5);
    chk("single_busy", Busy, 1);
    man_req = '0;
    repeat (7) tick();
    pulse_done();
    chk("single_release", Gnt, 0);
    chk("single_idle", Busy, 0);

    // Pointer now 3: requester 3 wins over 0 and 1
    setb(0, 8'h11, 1'b0);
    setb(1, 8'h77, 1'b1);
    setb(3, 8'h3C, 1'b1);
    man_req = 4'b1011;
    tick();
    chk("ptr_gnt", Gnt, 4'b1000);
    tick();
    chk("ptr_data", TxData, 8'h3C);
    man_req[3] = 1'b0;
    tick();
    pulse_done();
    chk("ptr_release", Gnt, 0);

    // Packet lock: 11,22,33 from req0 while req1 waits
    tick();
    chk("lock_gnt0", Gnt, 4'b0001);
    tick();
    chk("lock_b0", TxData, 8'h11);
    setb(0, 8'h22, 1'b0);
    tick();
    pulse_done();
    tick();
    tick();
    chk("lock_b1_start", TxStart, 1);
    chk("lock_b1", TxData, 8'h22);
    chk("lock_b1_gnt", Gnt, 4'b0001);
    setb(0, 8'h33, 1'b1);
    tick();
    pulse_done();
    tick();
    tick();
    chk("lock_b2", TxData, 8'h33);
    chk("lock_b2_gnt", Gnt, 4'b0001);
    man_req[0] = 1'b0;
    tick();
    pulse_done();
    tick();
    chk("lock_next_gnt", Gnt, 4'b0010);
    tick();
    chk("lock_next_data", TxData, 8'h77);
    man_req[1] = 1'b0;
    tick();
    pulse_done();

    // Watchdog: no TxDone for req2
    setb(2, 8'h5A, 1'b1);
    setb(3, 8'h6B, 1'b1);
    man_req = 4'b1100;
    tick();
    chk("wd_gnt", Gnt, 4'b0100);
    tick();
    chk("wd_data", TxData, 8'h5A);
    man_req[2] = 1'b0;
    n = 0;
    while (!Err && n < 40) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 16);
    chk("wd_release", Gnt, 0);
    tick();
    chk("wd_err_pulse", Err, 0);
    chk("wd_next_gnt", Gnt, 4'b1000);
    tick();
    chk("wd_next_data", TxData, 8'h6B);
    man_req[3] = 1'b0;

    // TxDone on the timeout cycle wins
    repeat (15) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("tie_no_err", Err, 0);
    chk("tie_release", Gnt, 0);
    tick();
    chk("tie_no_err2", Err, 0);

    // TxDone during LOAD is ignored
    setb(0, 8'h81, 1'b0);
    man_req = 4'b0001;
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("load_start", TxStart, 1);
    chk("load_data", TxData, 8'h81);
    n = 0;
    repeat (4) begin
      tick();
      if (TxStart) n++;
    end
    chk("load_done_ignored", n, 0);
    setb(0, 8'h82, 1'b0);
    pulse_done();
    tick();
    tick();
    chk("hold_b1", TxData, 8'h82);
    man_req = '0;
    pulse_done();

    // Stalled requester in HOLD: silent release
    n = 0;
    e = 0;
    while (Gnt != 0 && n < 40) begin
      tick();
      n++;
      if (Err) e++;
    end
    chk("hold_cycles", n, 16);
    chk("hold_no_err", e, 0);
    chk("hold_idle", Busy, 0);

    // Reset while waiting for TxDone
    setb(1, 8'hC3, 1'b1);
    man_req = 4'b0010;
    tick();
    tick();
    chk("rw_start", TxStart, 1);
    tick();
    tick();
    Rst = 1'b1;
    tick();
    chk("rw_gnt", Gnt, 0);
    chk("rw_outs", {Ack, TxStart, Busy, Err, TxData}, 0);
    man_req = '0;
    tick();
    Rst = 1'b0;
    tick();

    // Randomized packets against a round-robin packet model
    drv_auto = 1;
    tx_auto  = 1;
    mon_en   = 1;
    mp = 0;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            b.d = 8'($urandom);
            b.last = (k == len - 1);
            rq[i].push_back(b);
            mdl[i].push_back(b);
          end
        end
      end
      any = 1;
      while (any) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          if (sel < 0 && mdl[(mp + k) % N].size() > 0)
            sel = (mp + k) % N;
        end
        any = (sel >= 0);
        if (any) begin
          do begin
            b = mdl[sel].pop_front();
            x.id = sel;
            x.d = b.d;
            exp_q.push_back(x);
          end while (!b.last);
          mp = (sel + 1) % N;
        end
      end
      n = 0;
      tick();
      while ((exp_q.size() != 0 || Busy
              || rq[0].size() + rq[1].size()
               + rq[2].size() + rq[3].size() != 0)
             && n < 3000) begin
        tick();
        n++;
      end
      chk("rand_drain", (n < 3000), 1);
    end
    chk("rand_left", exp_q.size(), 0);
    chk("rand_err", rand_errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
